// File: rtl/wash_sequencer.sv
// Washing-machine cycle controller: sequences rinse/drain passes, dehydrate, warn, done from timer strobes.
// Optional per-phase watchdog with FAULT state is enabled by defining WASH_SEQ_WATCHDOG_EN.
module wash_sequencer #(
    parameter int unsigned RINSE_CYCLES = 2,
    parameter int unsigned CLR_CYCLES   = 4,
    parameter logic [31:0] WDOG_CYCLES  = 32'd700_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_n,
    input  logic       stop_n,
    input  logic       pause_sw,
    input  logic       rinse_tmr_n,
    input  logic       drain_tmr_n,
    input  logic       dehyd_tmr_n,
    input  logic       warn_tmr_n,
    output logic       timer_clr,
    output logic       timer_pause,
    output logic       water_valve,
    output logic       drain_valve,
    output logic       motor_on,
    output logic       buzzer,
    output logic [2:0] phase,
    output logic       done,
    output logic       fault
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RINSE = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_DEHYD = 3'd3;
    localparam logic [2:0] S_WARN  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
`ifdef WASH_SEQ_WATCHDOG_EN
    localparam logic [2:0] S_FAULT = 3'd6;
`endif

    localparam logic [3:0] RINSE_LAST = 4'(RINSE_CYCLES - 1);
    // One extra count beyond the low pulse provides the post-clear strobe mask cycle.
    localparam logic [4:0] CLR_LOAD   = 5'(CLR_CYCLES + 1);
    localparam logic       CFG_BAD    = (RINSE_CYCLES < 1) || (RINSE_CYCLES > 15) ||
                                        (CLR_CYCLES < 1) || (CLR_CYCLES > 15) ||
                                        (WDOG_CYCLES == 32'd0);

    logic [2:0] state_q, state_d;
    logic [3:0] rinse_cnt_q, rinse_cnt_d;
    logic [4:0] clr_cnt_q, clr_cnt_d;
    logic [3:0] strobe_hist_q, strobe_hist_d;
    logic       start_s1_q, start_s1_d, start_s2_q, start_s2_d, start_s3_q, start_s3_d;
    logic       stop_s1_q, stop_s1_d, stop_s2_q, stop_s2_d;
    logic       pause_s1_q, pause_s1_d, pause_s2_q, pause_s2_d;
`ifdef WASH_SEQ_WATCHDOG_EN
    logic [31:0] wdog_q, wdog_d;
`endif

    logic [3:0] tmr_n;
    logic [3:0] strobe_fall;
    logic       owned_fall;
    logic       active;
    logic       run;
    logic       masked;
    logic       stop_req;
    logic       start_req;
    logic       entered;
    logic       clr_pulse;

    assign tmr_n = {warn_tmr_n, dehyd_tmr_n, drain_tmr_n, rinse_tmr_n};

    always_comb begin
        start_s1_d    = start_n;
        start_s2_d    = start_s1_q;
        start_s3_d    = start_s2_q;
        stop_s1_d     = stop_n;
        stop_s2_d     = stop_s1_q;
        pause_s1_d    = pause_sw;
        pause_s2_d    = pause_s1_q;
        strobe_hist_d = tmr_n;
    end

    always_comb begin
        active      = (state_q >= S_RINSE) && (state_q <= S_WARN);
        run         = active && pause_s2_q;
        masked      = (clr_cnt_q != 5'd0);
        stop_req    = ~stop_s2_q;
        start_req   = ~start_s2_q & start_s3_q;
        strobe_fall = ~tmr_n & strobe_hist_q;
        owned_fall  = 1'b0;
        case (state_q)
            S_RINSE: owned_fall = strobe_fall[0];
            S_DRAIN: owned_fall = strobe_fall[1];
            S_DEHYD: owned_fall = strobe_fall[2];
            S_WARN:  owned_fall = strobe_fall[3];
            default: owned_fall = 1'b0;
        endcase
    end

    // Priority: stop, then start, then watchdog expiry, then the owned timer strobe.
    always_comb begin
        state_d     = state_q;
        rinse_cnt_d = rinse_cnt_q;
        entered     = 1'b0;
        clr_pulse   = 1'b0;
        if (stop_req) begin
            if (state_q != S_IDLE) begin
                state_d   = S_IDLE;
                entered   = 1'b1;
                clr_pulse = 1'b1;
            end
        end else if (((state_q == S_IDLE) || (state_q == S_DONE)) && start_req) begin
            state_d     = S_RINSE;
            rinse_cnt_d = 4'd0;
            entered     = 1'b1;
            clr_pulse   = 1'b1;
`ifdef WASH_SEQ_WATCHDOG_EN
        end else if (run && ((wdog_q + 32'd1) == WDOG_CYCLES)) begin
            state_d = S_FAULT;
            entered = 1'b1;
`endif
        end else if (run && !masked && owned_fall) begin
            entered   = 1'b1;
            clr_pulse = 1'b1;
            case (state_q)
                S_RINSE: state_d = S_DRAIN;
                S_DRAIN: begin
                    if (rinse_cnt_q == RINSE_LAST) begin
                        state_d = S_DEHYD;
                    end else begin
                        state_d     = S_RINSE;
                        rinse_cnt_d = rinse_cnt_q + 4'd1;
                    end
                end
                S_DEHYD: state_d = S_WARN;
                default: state_d = S_DONE;
            endcase
        end
    end

    always_comb begin
        if (clr_pulse) begin
            clr_cnt_d = CLR_LOAD;
        end else if (clr_cnt_q != 5'd0) begin
            clr_cnt_d = clr_cnt_q - 5'd1;
        end else begin
            clr_cnt_d = 5'd0;
        end
    end

`ifdef WASH_SEQ_WATCHDOG_EN
    always_comb begin
        if (entered) begin
            wdog_d = 32'd0;
        end else if (run) begin
            wdog_d = wdog_q + 32'd1;
        end else begin
            wdog_d = wdog_q;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            rinse_cnt_q   <= 4'd0;
            clr_cnt_q     <= 5'd0;
            strobe_hist_q <= 4'hF;
            start_s1_q    <= 1'b1;
            start_s2_q    <= 1'b1;
            start_s3_q    <= 1'b1;
            stop_s1_q     <= 1'b1;
            stop_s2_q     <= 1'b1;
            pause_s1_q    <= 1'b1;
            pause_s2_q    <= 1'b1;
`ifdef WASH_SEQ_WATCHDOG_EN
            wdog_q        <= 32'd0;
`endif
        end else begin
            state_q       <= state_d;
            rinse_cnt_q   <= rinse_cnt_d;
            clr_cnt_q     <= clr_cnt_d;
            strobe_hist_q <= strobe_hist_d;
            start_s1_q    <= start_s1_d;
            start_s2_q    <= start_s2_d;
            start_s3_q    <= start_s3_d;
            stop_s1_q     <= stop_s1_d;
            stop_s2_q     <= stop_s2_d;
            pause_s1_q    <= pause_s1_d;
            pause_s2_q    <= pause_s2_d;
`ifdef WASH_SEQ_WATCHDOG_EN
            wdog_q        <= wdog_d;
`endif
        end
    end

    assign timer_clr   = ~(clr_cnt_q > 5'd1);
    assign timer_pause = run;
    assign water_valve = run && (state_q == S_RINSE);
    assign drain_valve = run && ((state_q == S_DRAIN) || (state_q == S_DEHYD));
    assign motor_on    = run && ((state_q == S_RINSE) || (state_q == S_DEHYD));
    assign buzzer      = run && (state_q == S_WARN);
    assign done        = (state_q == S_DONE);
    assign phase       = state_q;

    // CFG_BAD flags an out-of-range parameter set; it is constant 0 for legal configurations.
`ifdef WASH_SEQ_WATCHDOG_EN
    assign fault = CFG_BAD || (state_q == S_FAULT);
`else
    assign fault = CFG_BAD;
`endif

endmodule

// File: tb/tb_wash_sequencer.sv
// Scoreboard bench for wash_sequencer: a phase-level reference model predicts every cycle's outputs.
module tb_wash_sequencer;

    localparam int RINSE = 2;
    localparam int CLR   = 4;
`ifdef WASH_SEQ_WATCHDOG_EN
    localparam logic [31:0] WDOG  = 32'd100;
    localparam bit          WD_ON = 1'b1;
`else
    localparam logic [31:0] WDOG  = 32'd700_000_000;
    localparam bit          WD_ON = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start_n, stop_n, pause_sw;
    logic       rinse_tmr_n, drain_tmr_n, dehyd_tmr_n, warn_tmr_n;
    logic       timer_clr, timer_pause, water_valve, drain_valve, motor_on, buzzer, done, fault;
    logic [2:0] phase;

    wash_sequencer #(.RINSE_CYCLES(RINSE), .CLR_CYCLES(CLR), .WDOG_CYCLES(WDOG)) dut (
        .clk(clk), .rst(rst), .start_n(start_n), .stop_n(stop_n), .pause_sw(pause_sw),
        .rinse_tmr_n(rinse_tmr_n), .drain_tmr_n(drain_tmr_n), .dehyd_tmr_n(dehyd_tmr_n),
        .warn_tmr_n(warn_tmr_n), .timer_clr(timer_clr), .timer_pause(timer_pause),
        .water_valve(water_valve), .drain_valve(drain_valve), .motor_on(motor_on),
        .buzzer(buzzer), .phase(phase), .done(done), .fault(fault)
    );

    typedef struct packed {
        logic [2:0] ph;
        logic       clr, tp, wv, dv, mo, bz, dn, ft;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   fails  = 0;
    bit   started = 1'b0;

    // Stimulus values applied on the next driven cycle.
    bit       r_rst = 1'b0, r_start = 1'b1, r_stop = 1'b1, r_pause = 1'b1;
    bit [3:0] r_strb = 4'hF;

    // Reference model: phase number, completed drain passes, cycles since last clear pulse,
    // watchdog age, and the raw key samples seen at the last three edges.
    int m_phase, m_passes, m_since, m_wd;
    bit st_h[3], sp_h[3], pz_h[3];
    bit [3:0] m_prev;

    task automatic model_step();
        bit stop, startfall, running, masked, fall, enter, pulse;
        int nxt;
        if (!r_rst) begin
            m_phase = 0; m_passes = 0; m_since = 1000; m_wd = 0; m_prev = 4'hF;
            for (int i = 0; i < 3; i++) begin st_h[i] = 1; sp_h[i] = 1; pz_h[i] = 1; end
            return;
        end
        stop      = !sp_h[1];
        startfall = !st_h[1] && st_h[2];
        running   = (m_phase >= 1) && (m_phase <= 4) && pz_h[1];
        masked    = (m_since <= CLR);
        fall      = 0;
        if (m_phase >= 1 && m_phase <= 4) fall = !r_strb[m_phase-1] && m_prev[m_phase-1];
        nxt = m_phase; enter = 0; pulse = 0;
        if (stop) begin
            if (m_phase != 0) begin nxt = 0; enter = 1; pulse = 1; end
        end else if ((m_phase == 0 || m_phase == 5) && startfall) begin
            nxt = 1; m_passes = 0; enter = 1; pulse = 1;
        end else if (WD_ON && running && (m_wd + 1 >= int'(WDOG))) begin
            nxt = 6; enter = 1;
        end else if (running && !masked && fall) begin
            enter = 1; pulse = 1;
            if (m_phase == 2) begin
                if (m_passes == RINSE - 1) nxt = 3;
                else begin nxt = 1; m_passes++; end
            end else if (m_phase == 4) nxt = 5;
            else nxt = m_phase + 1;
        end
        m_phase = nxt;
        if (enter) m_wd = 0; else if (running) m_wd++;
        if (pulse) m_since = 0; else if (m_since <= CLR) m_since++;
        m_prev = r_strb;
        for (int i = 2; i > 0; i--) begin st_h[i] = st_h[i-1]; sp_h[i] = sp_h[i-1]; pz_h[i] = pz_h[i-1]; end
        st_h[0] = r_start; sp_h[0] = r_stop; pz_h[0] = r_pause;
    endtask

    function automatic obs_t model_out();
        obs_t o;
        bit run;
        run  = (m_phase >= 1) && (m_phase <= 4) && pz_h[1];
        o.ph  = 3'(m_phase);
        o.clr = !(m_since < CLR);
        o.tp  = run;
        o.wv  = run && m_phase == 1;
        o.dv  = run && (m_phase == 2 || m_phase == 3);
        o.mo  = run && (m_phase == 1 || m_phase == 3);
        o.bz  = run && m_phase == 4;
        o.dn  = (m_phase == 5);
        o.ft  = WD_ON && (m_phase == 6);
        return o;
    endfunction

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            rst = r_rst; start_n = r_start; stop_n = r_stop; pause_sw = r_pause;
            {warn_tmr_n, dehyd_tmr_n, drain_tmr_n, rinse_tmr_n} = r_strb;
            model_step();
            exp_q.push_back(model_out());
            started = 1'b1;
        end
    endtask

    task automatic strobe(input int idx, input int low_cycles, input int gap);
        r_strb[idx] = 1'b0;
        tick(low_cycles);
        r_strb[idx] = 1'b1;
        tick(gap);
    endtask

    // Monitor: pops one prediction per edge and compares it with the sampled outputs.
    initial begin
        obs_t act, e;
        forever begin
            @(posedge clk);
            #1;
            if (started) begin
                act = {phase, timer_clr, timer_pause, water_valve, drain_valve, motor_on, buzzer, done, fault};
                checks++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL scoreboard_underflow at %0t: no prediction for outputs %h", $time, act);
                end else begin
                    e = exp_q.pop_front();
                    if (act !== e) begin
                        fails++;
                        $display("FAIL outputs at %0t: got ph=%0d clr=%b tp=%b wv=%b dv=%b mo=%b bz=%b dn=%b ft=%b, expected ph=%0d clr=%b tp=%b wv=%b dv=%b mo=%b bz=%b dn=%b ft=%b",
                                 $time, act.ph, act.clr, act.tp, act.wv, act.dv, act.mo, act.bz, act.dn, act.ft,
                                 e.ph, e.clr, e.tp, e.wv, e.dv, e.mo, e.bz, e.dn, e.ft);
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b0; start_n = 1'b1; stop_n = 1'b1; pause_sw = 1'b1;
        {warn_tmr_n, dehyd_tmr_n, drain_tmr_n, rinse_tmr_n} = 4'hF;

        r_rst = 1'b0; tick(3);
        r_rst = 1'b1; tick(2);

        // Start, then a full pass sequence with long-held strobes.
        r_start = 1'b0; tick(3); r_start = 1'b1; tick(6);
        strobe(0, 10, 8); strobe(1, 10, 8); strobe(0, 10, 8);
        strobe(1, 10, 8); strobe(2, 10, 8); strobe(3, 10, 8);

        // Restart from DONE; foreign strobes in RINSE are ignored.
        r_start = 1'b0; tick(2); r_start = 1'b1; tick(8);
        r_strb[3] = 1'b0; r_strb[1] = 1'b0; tick(4); r_strb = 4'hF; tick(4);

        // Advance to DEHYD and pause/resume there.
        strobe(0, 3, 8); strobe(1, 3, 8); strobe(0, 3, 8); strobe(1, 3, 8);
        r_pause = 1'b0; tick(6); r_pause = 1'b1; tick(6);

        // Stop coinciding with a drain strobe.
        r_start = 1'b0; r_stop = 1'b1; tick(1); r_start = 1'b1;
        r_stop = 1'b0; tick(1); r_stop = 1'b1; tick(3);
        r_start = 1'b0; tick(2); r_start = 1'b1; tick(8);
        strobe(0, 2, 8);
        r_strb[1] = 1'b0; r_stop = 1'b0; tick(4); r_strb = 4'hF; r_stop = 1'b1; tick(10);

        // Watchdog expiry when no strobe arrives, then recovery via stop.
        r_start = 1'b0; tick(2); r_start = 1'b1; tick(120);
        r_stop = 1'b0; tick(3); r_stop = 1'b1; tick(8);

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            r_rst = ($urandom_range(0, 499) != 0);
            if (!r_start) r_start = ($urandom_range(0, 2) == 0);
            else          r_start = ($urandom_range(0, 39) != 0);
            if (!r_stop)  r_stop  = ($urandom_range(0, 2) == 0);
            else          r_stop  = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 79) == 0) r_pause = !r_pause;
            for (int s = 0; s < 4; s++) begin
                if (!r_strb[s]) r_strb[s] = ($urandom_range(0, 3) == 0);
                else            r_strb[s] = ($urandom_range(0, 14) != 0);
            end
            tick(1);
        end
        r_rst = 1'b1; r_stop = 1'b1; r_start = 1'b1; r_strb = 4'hF; tick(4);

        for (int w = 0; w < 10 && exp_q.size() != 0; w++) @(negedge clk);
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain_scoreboard: %0d predictions left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
